text_console: RTL and testbench

Character-stream writer for the text-mode VGA display. It accepts ASCII bytes from the CPU through memory-mapped I/O registers and buffers them in a small FIFO. It tracks a cursor and converts the bytes into single-cycle writes of the 80x30 text RAM, including line wrap, carriage return, backspace, line clear and whole-screen clear. It sits on the CPU I/O bus beside the gpu. Top level routes v_w_en, v_address and v_din to the gpu's text-RAM write port.

---
 rtl/text_console.sv | 214 +++++++++++++++++++++
 tb/tb_text_console.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console.sv
// text_console: CPU character stream -> 80x30 text-RAM cell writes (wrap, CR, LF, BS, line/screen clear).
// Latency: printable char pushed at edge E is popped at E+1 and written at E+2; one char per 2 cycles sustained.
// Backpressure: 4-entry FIFO; a DATA push while full is dropped and sets the sticky overflow flag.
// Optional feature macro: TEXT_CONSOLE_CLEAR_ON_RESET_EN (clear_pending resets to 1, screen cleared after reset).
module text_console #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter logic [11:0] IO_BASE    = 12'h081,
  parameter logic [7:0]  BLANK      = 8'h20,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic [11:0] address,
  input  logic        io_w_en,
  input  logic        io_r_en,
  output logic [7:0]  dout,
  output logic        v_w_en,
  output logic [11:0] v_address,
  output logic [7:0]  v_din,
  output logic        busy
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CELLS = COLS * ROWS;

  localparam logic [11:0] ADDR_DATA   = IO_BASE;
  localparam logic [11:0] ADDR_STATUS = IO_BASE + 12'd1;
  localparam logic [11:0] ADDR_COL    = IO_BASE + 12'd2;
  localparam logic [11:0] ADDR_ROW    = IO_BASE + 12'd3;

`ifdef TEXT_CONSOLE_CLEAR_ON_RESET_EN
  localparam logic CLR_RST = 1'b1;
`else
  localparam logic CLR_RST = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PUT, LINE_CLR, SCR_CLR} state_t;

  state_t        state;
  logic [7:0]    char_q;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [11:0]   counter;
  logic          overflow;
  logic          clear_pending;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          full;
  logic          empty;
  logic          sel_data;
  logic          sel_status;
  logic          sel_col;
  logic          sel_row;
  logic          push;
  logic          pop;
  logic [11:0]   row_base;
  logic [11:0]   cell_addr;
  logic [RW-1:0] next_row;
  logic          printable;

  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign sel_data   = io_w_en && (address == ADDR_DATA);
  assign sel_status = io_w_en && (address == ADDR_STATUS);
  assign sel_col    = io_w_en && (address == ADDR_COL);
  assign sel_row    = io_w_en && (address == ADDR_ROW);
  // A full FIFO refuses the push even when a pop happens on the same edge.
  assign push       = sel_data && !full;
  // A pending screen clear always wins over queued characters.
  assign pop        = (state == IDLE) && !clear_pending && !empty;
  assign busy       = (state != IDLE) || !empty || clear_pending;

  assign row_base   = 12'(row) * 12'(COLS);
  assign cell_addr  = row_base + 12'(col);
  // No scrolling: the cursor row wraps back to the top line.
  assign next_row   = (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
  assign printable  = (char_q >= 8'h20) && (char_q <= 8'h7E);

  // Character storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= din;
  end

  // FIFO pointers and occupancy; push and pop on one edge both take effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Cursor FSM with registered text-RAM write port, plus register-side updates of the cursor and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      char_q        <= '0;
      col           <= '0;
      row           <= '0;
      counter       <= '0;
      overflow      <= 1'b0;
      clear_pending <= CLR_RST;
      v_w_en        <= 1'b0;
      v_address     <= '0;
      v_din         <= '0;
    end else begin
      v_w_en <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_pending) begin
            counter <= '0;
            state   <= SCR_CLR;
          end else if (!empty) begin
            char_q <= fifo_mem[rd_ptr];
            state  <= PUT;
          end
        end
        PUT: begin
          state <= IDLE;
          if (printable) begin
            v_w_en    <= 1'b1;
            v_address <= cell_addr;
            v_din     <= char_q;
            if (col < CW'(COLS - 1)) begin
              col <= col + CW'(1);
            end else begin
              col     <= '0;
              row     <= next_row;
              counter <= '0;
              state   <= LINE_CLR;
            end
          end else if (char_q == 8'h0A) begin
            col     <= '0;
            row     <= next_row;
            counter <= '0;
            state   <= LINE_CLR;
          end else if (char_q == 8'h0D) begin
            col <= '0;
          end else if (char_q == 8'h08) begin
            // Backspace at column 0 is a no-op.
            if (col != '0) begin
              col       <= col - CW'(1);
              v_w_en    <= 1'b1;
              v_address <= cell_addr - 12'd1;
              v_din     <= BLANK;
            end
          end
        end
        LINE_CLR: begin
          v_w_en    <= 1'b1;
          v_address <= row_base + counter;
          v_din     <= BLANK;
          if (counter == 12'(COLS - 1)) state <= IDLE;
          else counter <= counter + 12'd1;
        end
        SCR_CLR: begin
          v_w_en    <= 1'b1;
          v_address <= counter;
          v_din     <= BLANK;
          if (counter == 12'(CELLS - 1)) begin
            row           <= '0;
            col           <= '0;
            clear_pending <= 1'b0;
            state         <= IDLE;
          end else begin
            counter <= counter + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // Register writes come last so a fresh clear request is never lost to a finishing clear.
      if (sel_data && full) overflow <= 1'b1;
      if (sel_status) begin
        if (din[0]) clear_pending <= 1'b1;
        if (din[2]) overflow      <= 1'b0;
      end
      // Cursor moves from the CPU only while fully idle, so they never race the FSM.
      if (sel_col && !busy && (din < 8'(COLS))) col <= din[CW-1:0];
      if (sel_row && !busy && (din < 8'(ROWS))) row <= din[RW-1:0];
    end
  end

  // Registered read port; unmapped addresses keep the previous value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (io_r_en) begin
      case (address)
        ADDR_STATUS: dout <= {5'b0, overflow, full, busy};
        ADDR_COL:    dout <= 8'(col);
        ADDR_ROW:    dout <= 8'(row);
        default:     dout <= dout;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Testbench for text_console: directed steps plus randomized character streams
// checked against a screen-rule model (expected cell writes and cursor position).
module tb_text_console;
  localparam int          COLS  = 80;
  localparam int          ROWS  = 30;
  localparam logic [11:0] BASE  = 12'h081;
  localparam logic [7:0]  BLANK = 8'h20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = '0;
  logic [11:0] address = '0;
  logic        io_w_en = 1'b0;
  logic        io_r_en = 1'b0;
  logic [7:0]  dout;
  logic        v_w_en;
  logic [11:0] v_address;
  logic [7:0]  v_din;
  logic        busy;

  text_console dut (
    .clk(clk), .rst(rst), .din(din), .address(address), .io_w_en(io_w_en),
    .io_r_en(io_r_en), .dout(dout), .v_w_en(v_w_en), .v_address(v_address),
    .v_din(v_din), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [19:0] obs_q[$];
  logic [19:0] exp_q[$];
  int m_row = 0;
  int m_col = 0;

  // Capture every text-RAM write 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (v_w_en === 1'b1) obs_q.push_back({v_address, v_din});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_write(input int addr, input logic [7:0] d);
    exp_q.push_back({12'(addr), d});
  endtask

  task automatic model_line_clear();
    for (int k = 0; k < COLS; k++) expect_write(m_row * COLS + k, BLANK);
  endtask

  // Screen rules: what one character does to the cursor and which cells it writes.
  task automatic model_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      expect_write(m_row * COLS + m_col, c);
      if (m_col < COLS - 1) m_col++;
      else begin
        m_col = 0; m_row = (m_row + 1) % ROWS; model_line_clear();
      end
    end else if (c == 8'h0A) begin
      m_col = 0; m_row = (m_row + 1) % ROWS; model_line_clear();
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h08) begin
      if (m_col > 0) begin
        m_col--; expect_write(m_row * COLS + m_col, BLANK);
      end
    end
  endtask

  task automatic model_screen_clear();
    for (int k = 0; k < COLS * ROWS; k++) expect_write(k, BLANK);
    m_row = 0; m_col = 0;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; din = d; io_w_en = 1'b1;
    @(negedge clk);
    io_w_en = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [7:0] d);
    @(negedge clk);
    address = a; io_r_en = 1'b1;
    @(negedge clk);
    io_r_en = 1'b0;
    d = dout;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge clk); n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic compare_writes(input string tag);
    int bad = -1;
    int idx;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
    idx = (bad >= 0) ? bad : ((obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size()) - 1;
    if (idx >= 0) check({tag, "_write"}, 32'(obs_q[idx]), 32'(exp_q[idx]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_cursor(input string tag);
    logic [7:0] r;
    bus_read(BASE + 12'd2, r); check({tag, "_col"}, 32'(r), 32'(m_col));
    bus_read(BASE + 12'd3, r); check({tag, "_row"}, 32'(r), 32'(m_row));
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] burst [6];
    logic [7:0] c;
    int nw;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_v_w_en", 32'(v_w_en), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_v_address", 32'(v_address), 32'd0);
    check("rst_v_din", 32'(v_din), 32'd0);
`ifdef TEXT_CONSOLE_CLEAR_ON_RESET_EN
    check("rst_busy", 32'(busy), 32'd1);
    model_screen_clear();
    wait_idle("rst_clear_idle", 3000);
    compare_writes("rst_clear");
`else
    check("rst_busy", 32'(busy), 32'd0);
`endif

    // Single printable character: write lands exactly two edges after the push
    bus_write(BASE, 8'h41);
    check("t1_e0_wen", 32'(v_w_en), 32'd0);
    @(negedge clk); check("t1_e1_wen", 32'(v_w_en), 32'd0);
    @(negedge clk); check("t1_e2_wen", 32'(v_w_en), 32'd1);
    check("t1_e2_addr", 32'(v_address), 32'd0);
    check("t1_e2_din", 32'(v_din), 32'h41);
    @(negedge clk); check("t1_e3_wen", 32'(v_w_en), 32'd0);
    model_char(8'h41);
    wait_idle("t1_idle", 50);
    compare_writes("t1");
    bus_read(BASE + 12'd2, r); check("t1_col", 32'(r), 32'd1);

    // Last cell of screen wraps to row 0 and clears it
    bus_write(BASE + 12'd3, 8'd29); m_row = 29;
    bus_write(BASE + 12'd2, 8'd79); m_col = 79;
    bus_write(BASE, 8'h5A);
    model_char(8'h5A);
    wait_idle("t2_idle", 300);
    compare_writes("t2");
    check_cursor("t2");
    check("t2_busy", 32'(busy), 32'd0);

    // CR and BS at column 0 write nothing; BS at column 5 blanks cell 4
    bus_write(BASE, 8'h0D); model_char(8'h0D);
    bus_write(BASE, 8'h08); model_char(8'h08);
    wait_idle("t3_idle_a", 50);
    compare_writes("t3_nowrite");
    bus_write(BASE + 12'd2, 8'd5); m_col = 5;
    bus_write(BASE, 8'h08); model_char(8'h08);
    wait_idle("t3_idle_b", 50);
    compare_writes("t3_bs");
    bus_read(BASE + 12'd2, r); check("t3_col", 32'(r), 32'd4);

    // Out-of-range cursor writes are ignored
    bus_write(BASE + 12'd2, 8'd80);
    bus_write(BASE + 12'd3, 8'd30);
    check_cursor("t3_range");

    // Overflow: six pushes during a line clear, only four fit
    bus_write(BASE + 12'd2, 8'd79); m_col = 79;
    bus_write(BASE, 8'h21); model_char(8'h21);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) burst[i] = 8'($urandom_range(32, 126));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      address = BASE; din = burst[i]; io_w_en = 1'b1;
    end
    @(negedge clk); io_w_en = 1'b0;
    for (int i = 0; i < 4; i++) model_char(burst[i]);
    bus_read(BASE + 12'd1, r); check("t4_status", 32'(r), 32'h07);
    bus_write(BASE + 12'd1, 8'h04);
    bus_read(BASE + 12'd1, r); check("t4_ovf_cleared", 32'(r[2]), 32'd0);
    wait_idle("t4_idle", 400);
    compare_writes("t4");
    check_cursor("t4");

    // Screen clear requested while busy beats two queued characters
    bus_write(BASE + 12'd2, 8'd79); m_col = 79;
    bus_write(BASE, 8'h22); model_char(8'h22);
    bus_write(BASE, 8'h43);
    bus_write(BASE, 8'h44);
    bus_write(BASE + 12'd1, 8'h01);
    model_screen_clear();
    model_char(8'h43);
    model_char(8'h44);
    wait_idle("t5_idle", 3000);
    compare_writes("t5");
    check_cursor("t5");

    // Reset 100 cycles into a screen clear
    bus_write(BASE + 12'd1, 8'h01);
    nw = 0;
    while (obs_q.size() < 100 && nw < 400) begin
      @(negedge clk); nw++;
    end
    check("t6_reach100", obs_q.size(), 32'd100);
    rst = 1'b1;
    #1;
    check("t6_wen_drop", 32'(v_w_en), 32'd0);
    for (int k = 0; k < 100; k++) expect_write(k, BLANK);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_row = 0; m_col = 0;
`ifdef TEXT_CONSOLE_CLEAR_ON_RESET_EN
    model_screen_clear();
    @(negedge clk);
    wait_idle("t6_idle", 3000);
`else
    repeat (30) @(negedge clk);
    check("t6_busy", 32'(busy), 32'd0);
`endif
    compare_writes("t6");
    bus_read(BASE + 12'd1, r); check("t6_status", 32'(r), 32'h00);
    check_cursor("t6");

    // Random cursor placement and short character streams
    for (int it = 0; it < 30; it++) begin
      int rr, cc, n;
      rr = $urandom_range(0, ROWS - 1);
      cc = $urandom_range(0, COLS - 1);
      bus_write(BASE + 12'd3, 8'(rr)); m_row = rr;
      bus_write(BASE + 12'd2, 8'(cc)); m_col = cc;
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        case ($urandom_range(0, 7))
          0, 1, 2, 3: c = 8'($urandom_range(32, 126));
          4:       c = 8'h0A;
          5:       c = 8'h0D;
          6:       c = 8'h08;
          default: begin
            case ($urandom_range(0, 3))
              0:       c = 8'h00;
              1:       c = 8'h7F;
              2:       c = 8'h1B;
              default: c = 8'hFF;
            endcase
          end
        endcase
        bus_write(BASE, c);
        model_char(c);
      end
      wait_idle("rnd_idle", 400);
      compare_writes("rnd");
      check_cursor("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
